// File: rtl/random_pkg.sv
// random_pkg: dispatcher state type and the bound-to-rejection-mask helper.
package random_pkg;
  typedef enum logic [1:0] {IDLE, DRAW, DELIVER} state_t;
  // Smears bound-1 rightward, giving the smallest 2^k-1 covering bound-1.
  function automatic logic [31:0] mask_for_bound(input logic [31:0] bound);
    logic [31:0] m;
    m = bound - 32'd1;
    for (int i = 0; i < 5; i++) m = m | (m >> (1 << i));
    return m;
  endfunction
endpackage

// File: rtl/random_lfsr_core.sv
// random_lfsr_core: free-running Galois LFSR with a load port; zero loads fall back to SEED.
module random_lfsr_core #(
  parameter int N = 16,
  parameter logic [N-1:0] SEED = 16'h8001
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         LOAD,
  input  logic [N-1:0] LOAD_VALUE,
  output logic [N-1:0] LFSR
);
  localparam logic [N-1:0] TAPS = (N'(1) << 1) | (N'(1) << (N - 2));
  always_ff @(posedge CLK)
    if (RST) LFSR <= SEED;
    else if (LOAD) LFSR <= (LOAD_VALUE == '0) ? SEED : LOAD_VALUE;
    else LFSR <= {LFSR[N-2:0], LFSR[N-1]} ^ (TAPS & {N{LFSR[N-1]}});
endmodule

// File: rtl/random_dispatcher.sv
// random_dispatcher: round-robin shared LFSR service returning bounded values by masked rejection sampling.
module random_dispatcher
  import random_pkg::*;
#(
  parameter int N = 16,
  parameter int REQ = 4,
  parameter logic [N-1:0] SEED = 16'h8001,
  parameter int MAX_TRIES = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REQ-1:0]   REQ_VALID,
  input  logic [REQ*N-1:0] REQ_BOUND,
  input  logic             RESEED_VALID,
  input  logic [N-1:0]     RESEED_VALUE,
  output logic [REQ-1:0]   GRANT,
  output logic [N-1:0]     RANDOM_OUT,
  output logic             RANDOM_VALID,
  output logic             BUSY
);
  localparam int IW = $clog2(REQ);
  localparam int TW = $clog2(MAX_TRIES + 1);
  state_t state;
  logic [IW-1:0] rr_ptr, idx, pick, j;
  logic found, accept, give_up;
  logic [N-1:0] lfsr, bound, mask, cand, result, pick_bound;
  logic [TW-1:0] tries;
  random_lfsr_core #(.N(N), .SEED(SEED)) u_lfsr (
    .CLK(CLK), .RST(RST), .LOAD(RESEED_VALID), .LOAD_VALUE(RESEED_VALUE), .LFSR(lfsr)
  );
  // Walk offsets high to low so the nearest set bit at or after rr_ptr wins.
  always_comb begin
    found = 1'b0;
    pick = rr_ptr;
    j = '0;
    for (int i = REQ - 1; i >= 0; i--) begin
      j = IW'((int'(rr_ptr) + i) % REQ);
      if (REQ_VALID[j]) begin
        found = 1'b1;
        pick = j;
      end
    end
  end
  assign pick_bound = REQ_BOUND[int'(pick)*N +: N];
  assign cand = lfsr & mask;
  assign accept = (bound == '0) || (cand < bound);
  assign give_up = tries == TW'(MAX_TRIES - 1);
  assign result = accept ? cand : cand - bound;
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      rr_ptr <= '0;
      idx <= '0;
      tries <= '0;
      bound <= '0;
      mask <= '0;
      GRANT <= '0;
      RANDOM_VALID <= 1'b0;
      RANDOM_OUT <= '0;
      BUSY <= 1'b0;
    end else begin
      GRANT <= '0;
      RANDOM_VALID <= 1'b0;
      case (state)
        IDLE: if (found) begin
          idx <= pick;
          bound <= pick_bound;
          mask <= N'(mask_for_bound(32'(pick_bound)));
          tries <= '0;
          BUSY <= 1'b1;
          state <= DRAW;
        end
        DRAW: if (accept || give_up) begin
          GRANT <= REQ'(1) << idx;
          RANDOM_VALID <= 1'b1;
          RANDOM_OUT <= result;
          state <= DELIVER;
        end else tries <= tries + 1'b1;
        DELIVER: begin
          rr_ptr <= (idx == IW'(REQ - 1)) ? '0 : idx + 1'b1;
          BUSY <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/random_dispatcher.md
# random_dispatcher

Shared random-number service for the game logic. Owns one free-running N-bit Galois LFSR and shares it between REQ requesters, such as enemy spawner, item drop or map generator. Each request is granted round-robin and returns one uniform value in [0, bound), produced by masked rejection sampling with a bounded retry count. Sits between the per-entity game FSMs and the single random source, so no requester instantiates its own generator.

## Interface

- N, 16: LFSR / result width; N >= 5
- REQ, 4: number of requesters; REQ >= 2
- SEED, 16'h8001: reset and zero-substitute seed (bits 0 and N-1 set)
- MAX_TRIES, 8: rejection draws before fallback; >= 1
- CLK  in  1  clock; one clock domain
- RST  in  1  reset, synchronous, active-high
- REQ_VALID  in  REQ  per-requester request; held until its GRANT bit
- REQ_BOUND  in  REQ*N  per-requester exclusive upper bound, slice i = [i*N +: N]; 0 = full N-bit range
- RESEED_VALID  in  1  one-cycle load of RESEED_VALUE into LFSR
- RESEED_VALUE  in  N  new seed
- GRANT  out  REQ  one-hot, one-cycle pulse naming the served requester
- RANDOM_OUT  out  N  result, valid with RANDOM_VALID
- RANDOM_VALID  out  1  one-cycle result strobe, coincident with GRANT
- BUSY  out  1  high in DRAW and DELIVER

## Operation

- LFSR steps every cycle (cur -> next):
  - next[0]=cur[N-1]
  - next[1]=cur[0]^cur[N-1]
  - next[k]=cur[k-1] for k=2..N-3
  - next[N-2]=cur[N-3]^cur[N-1]
  - next[N-1]=cur[N-2]
- RESEED_VALID, any state: the LFSR loads RESEED_VALUE that cycle instead of stepping. A value of 0 loads SEED. Has priority over stepping.
- FSM states IDLE, DRAW, DELIVER:
  - IDLE: if any REQ_VALID, pick the first set bit searching from rr_ptr upward with wrap. Latch index, bound, mask, and tries=0. Go to DRAW.
  - Mask is the smallest 2^k-1 >= bound-1. Bound 1 gives mask 0. Bound 0 means no mask and accept unconditionally.
  - DRAW: cand = LFSR & mask.
    - If bound==0 or cand < bound, accept cand and go to DELIVER.
    - Otherwise tries++. If tries reaches MAX_TRIES, accept cand-bound (always < bound since mask < 2*bound) and go to DELIVER.
    - Otherwise stay in DRAW.
  - DELIVER: GRANT[idx]=1, RANDOM_VALID=1, RANDOM_OUT=result. Set rr_ptr = idx+1 mod REQ. Go to IDLE.
- REQ_VALID/REQ_BOUND changes after latching do not affect the in-flight draw. A withdrawn request is still granted. Requesters must drop REQ_VALID in the GRANT cycle.
- Arithmetic is unsigned N-bit. Compare and subtract have no carry-out.

## Timing

- Reset values:
  - State IDLE, LFSR=SEED, rr_ptr=0, tries=0
  - GRANT=0, RANDOM_VALID=0, RANDOM_OUT=0, BUSY=0
- All outputs are registered.
- Latency: request sampled in IDLE at cycle t; best-case GRANT/RANDOM_VALID at t+2; worst case t+1+MAX_TRIES.
- Minimum spacing between grants is 3 cycles: DELIVER -> IDLE -> DRAW -> DELIVER.
- RANDOM_OUT holds its last value after the strobe. It changes only in a DELIVER cycle.
- RST mid-DRAW or mid-DELIVER: the next cycle is IDLE with no GRANT issued. The pending request is lost.
- Reseed in the same cycle as a DRAW sample: that cycle samples the pre-load LFSR value.

## Structure

- Package random_pkg holds the state enum (IDLE, DRAW, DELIVER) and a mask_for_bound function.
- Sub-module random_lfsr_core holds the N-bit LFSR with load port and zero-to-SEED substitution. The dispatcher holds the FSM, arbiter and sampler.

## Test plan

- Reset: all outputs 0 and BUSY 0. random_lfsr_core steps 0x8001 -> 0x4001 with N=16.
- Requester 2 only, bound 1: GRANT=4'b0100 and RANDOM_OUT=0 exactly 2 cycles after the request; BUSY high for 2 cycles.
- All four REQ_VALID held with bound 0, each dropped on grant and re-raised: grants in order 0,1,2,3,0, 3 cycles apart. RANDOM_OUT matches the reference LFSR model sampled at each DRAW cycle.
- Bound 10, 1000 requests: every RANDOM_OUT < 10 and all values 0..9 occur. With MAX_TRIES=1, a rejected cand (e.g. 13) yields 3.
- RESEED_VALUE=0 pulse gives LFSR=SEED next cycle. Reseed during DRAW: the draw completes and the result is < bound.
- RST during DRAW: next cycle IDLE with GRANT=0, rr_ptr=0 and LFSR=SEED.
